dwt_row_pair_buffer: RTL and testbench

- Upstream feeder of the 2-D DWT column stage.
- Accepts a raster-order 8-bit pixel stream for frames that are 8 pixels wide and NUM_ROWS rows tall.
- Packs each pair of consecutive rows (even, odd) into two 64-bit words and presents them together for the per-lane average/difference stage.
- Handshaked on both sides; backpressure stalls the pixel source.

---
 rtl/dwt_row_pair_buffer.sv | 62 ++++++
 tb/tb_dwt_row_pair_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dwt_row_pair_buffer.sv
// dwt_row_pair_buffer: packs even/odd 8-pixel rows of a raster stream into paired 64-bit words
module dwt_row_pair_buffer #(
  parameter int NUM_ROWS = 8,
  parameter int PAIR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [63:0]       pixel_out1,
  output logic [63:0]       pixel_out2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [PAIR_W-1:0] pair_idx
);
  typedef enum logic {FILL_EVEN, FILL_ODD} state_t;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_ROWS / 2 - 1);
  state_t state, state_nx;
  logic [2:0] col;
  logic [63:0] even_asm, odd_asm;
  logic [PAIR_W-1:0] fill_cnt;
  logic accept, done, cnt_last;
  always_comb begin
    pix_ready = !(state == FILL_ODD && col == 3'd7 && out_valid && !out_ready);
    accept = pix_valid && pix_ready;
    done = accept && state == FILL_ODD && col == 3'd7;
    cnt_last = fill_cnt == LAST_PAIR;
    state_nx = (accept && col == 3'd7) ? (state == FILL_EVEN ? FILL_ODD : FILL_EVEN) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL_EVEN;
      col <= '0;
      fill_cnt <= '0;
      even_asm <= '0;
      odd_asm <= '0;
      pixel_out1 <= '0;
      pixel_out2 <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      pair_idx <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        col <= col + 3'd1;
        if (state == FILL_EVEN) even_asm[{col, 3'b000} +: 8] <= pix_in;
        else odd_asm[{col, 3'b000} +: 8] <= pix_in;
      end
      // lane 7 of the odd row arrives this cycle, so splice it straight into the output
      if (done) begin
        pixel_out1 <= even_asm;
        pixel_out2 <= {pix_in, odd_asm[55:0]};
        pair_idx <= fill_cnt;
        out_last <= cnt_last;
        fill_cnt <= cnt_last ? '0 : fill_cnt + PAIR_W'(1);
      end
      out_valid <= done || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_dwt_row_pair_buffer.sv
// tb_dwt_row_pair_buffer: randomized scoreboard bench for the row pair buffer
module tb_dwt_row_pair_buffer;
  logic clk = 0, rst = 0;
  logic [7:0] pix_in = 0;
  logic pix_valid = 0, out_ready = 0;
  logic pix_ready, out_valid, out_last;
  logic [63:0] pixel_out1, pixel_out2;
  logic [2:0] pair_idx;
  logic pix_ready2, out_valid2, out_last2;
  logic [63:0] pixel_out1_2, pixel_out2_2;
  logic [0:0] pair_idx2;
  int checks = 0, errors = 0;
  bit mon_en = 0;

  typedef struct packed {logic [63:0] a; logic [63:0] b; logic [2:0] idx; logic last;} pair_t;
  pair_t q[$];
  logic [7:0] pbuf[$];
  int npair = 0;

  always #5 clk = ~clk;

  dwt_row_pair_buffer #(.NUM_ROWS(8), .PAIR_W(3)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pixel_out1(pixel_out1), .pixel_out2(pixel_out2), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .pair_idx(pair_idx));

  dwt_row_pair_buffer #(.NUM_ROWS(2), .PAIR_W(1)) dut2 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready2),
    .pixel_out1(pixel_out1_2), .pixel_out2(pixel_out2_2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_last(out_last2), .pair_idx(pair_idx2));

  // reference: pairs are consecutive 16-pixel groups of the accepted stream, at most one waiting
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      automatic bit ev = q.size() > 0;
      automatic bit exp_rdy = !(pbuf.size() == 15 && ev && !out_ready);
      checks++;
      if (out_valid !== ev) begin errors++; $display("FAIL mon_out_valid got %b want %b", out_valid, ev); end
      checks++;
      if (pix_ready !== exp_rdy) begin errors++; $display("FAIL mon_pix_ready got %b want %b", pix_ready, exp_rdy); end
      if (ev) begin
        checks++;
        if ({pixel_out1, pixel_out2, pair_idx, out_last} !== q[0]) begin
          errors++;
          $display("FAIL mon_pair got %h %h idx=%0d last=%b want %h %h idx=%0d last=%b",
                   pixel_out1, pixel_out2, pair_idx, out_last, q[0].a, q[0].b, q[0].idx, q[0].last);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (pix_valid && exp_rdy) begin
        pbuf.push_back(pix_in);
        if (pbuf.size() == 16) begin
          automatic pair_t p;
          for (int k = 0; k < 8; k++) begin
            p.a[8*k +: 8] = pbuf[k];
            p.b[8*k +: 8] = pbuf[8+k];
          end
          p.idx = 3'(npair % 4);
          p.last = (npair % 4) == 3;
          q.push_back(p);
          pbuf.delete();
          npair++;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1; pix_valid = 0; pix_in = 8'($urandom);
    q.delete(); pbuf.delete(); npair = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic send(input logic [7:0] v, input int gap);
    bit acc;
    int n;
    repeat (gap) begin pix_valid = 0; pix_in = 8'($urandom); @(posedge clk); #1; end
    pix_valid = 1; pix_in = v; n = 0;
    do begin
      @(negedge clk); acc = pix_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 100);
    if (!acc) begin checks++; errors++; $display("FAIL send_timeout pixel %h not accepted", v); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pix_ready, out_valid, out_last, pair_idx, pixel_out1, pixel_out2} !== {1'b1, 1'b0, 1'b0, 3'd0, 128'h0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b v=%b last=%b idx=%0d %h %h want rdy=1 all else 0",
               pix_ready, out_valid, out_last, pair_idx, pixel_out1, pixel_out2);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      out_ready = i[0]; pix_in = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, pair_idx, pixel_out1, pixel_out2} !== '0) begin
        errors++; $display("FAIL idle_outputs cycle %0d got v=%b %h %h want 0", i, out_valid, pixel_out1, pixel_out2);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 64; i++) begin
      send(8'(i), 0);
      if (i == 15) begin
        checks++;
        if ({out_valid, pixel_out1, pixel_out2, pair_idx, out_last} !== {1'b1, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 3'd0, 1'b0}) begin
          errors++; $display("FAIL stream_pair0 got v=%b %h %h idx=%0d last=%b", out_valid, pixel_out1, pixel_out2, pair_idx, out_last);
        end
      end
      if (i == 63) begin
        checks++;
        if ({out_valid, pair_idx, out_last} !== {1'b1, 3'd3, 1'b1}) begin
          errors++; $display("FAIL stream_pair3_last got v=%b idx=%0d last=%b want 1 3 1", out_valid, pair_idx, out_last);
        end
      end
    end
    pix_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 31; i++) send(8'(i), 0);
    pix_in = 8'd31;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({pix_ready, out_valid, pixel_out1, pixel_out2} !== {1'b0, 1'b1, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908}) begin
        errors++; $display("FAIL bp_stall got rdy=%b v=%b %h %h want rdy=0 pair0 held", pix_ready, out_valid, pixel_out1, pixel_out2);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", pix_ready); end
    @(posedge clk); #1;
    pix_valid = 0;
    checks++;
    if ({out_valid, pixel_out1, pixel_out2, pair_idx} !== {1'b1, 64'h1716151413121110, 64'h1F1E1D1C1B1A1918, 3'd1}) begin
      errors++; $display("FAIL bp_pair1 got v=%b %h %h idx=%0d", out_valid, pixel_out1, pixel_out2, pair_idx);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_gaps();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 128; i++) begin
      send(8'(i), ($urandom % 3 == 0) ? int'($urandom_range(1, 5)) : 0);
      if (i % 16 == 15) begin
        checks++;
        if ({out_valid, pair_idx} !== {1'b1, 3'((i / 16) % 4)}) begin
          errors++; $display("FAIL gap_pair_idx got v=%b idx=%0d want 1 %0d", out_valid, pair_idx, (i / 16) % 4);
        end
      end
    end
    pix_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random_ready();
    do_reset();
    for (int i = 0; i < 96; i++) begin
      out_ready = 1'($urandom);
      send(8'($urandom), int'($urandom_range(0, 2)));
    end
    pix_valid = 0; out_ready = 1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 43; i++) send(8'(i), 0);
    do_reset();
    checks++;
    if ({out_valid, pix_ready} !== 2'b01) begin
      errors++; $display("FAIL midrst_state got v=%b rdy=%b want 0 1", out_valid, pix_ready);
    end
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i), 0);
    pix_valid = 0;
    checks++;
    if ({out_valid, pixel_out1, pixel_out2, pair_idx} !== {1'b1, 64'hA7A6A5A4A3A2A1A0, 64'hAFAEADACABAAA9A8, 3'd0}) begin
      errors++; $display("FAIL midrst_pair got v=%b %h %h idx=%0d", out_valid, pixel_out1, pixel_out2, pair_idx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_two_rows();
    logic [7:0] px[16];
    logic [63:0] ea, eb;
    do_reset();
    out_ready = 1;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 16; k++) px[k] = 8'($urandom);
      for (int k = 0; k < 8; k++) begin ea[8*k +: 8] = px[k]; eb[8*k +: 8] = px[8+k]; end
      for (int k = 0; k < 16; k++) send(px[k], 0);
      checks++;
      if ({out_valid2, pixel_out1_2, pixel_out2_2, pair_idx2, out_last2} !== {1'b1, ea, eb, 1'b0, 1'b1}) begin
        errors++; $display("FAIL rows2_pair%0d got v=%b %h %h idx=%0d last=%b want 1 %h %h 0 1",
                           p, out_valid2, pixel_out1_2, pixel_out2_2, pair_idx2, out_last2, ea, eb);
      end
    end
    pix_valid = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    mon_en = 1;
    test_reset();
    test_idle();
    test_stream();
    test_backpressure();
    test_gaps();
    test_random_ready();
    test_mid_reset();
    test_two_rows();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
